pci_cfg_enumerator: RTL and testbench

Boot-time configuration sequencer that drives the PCI host bridge's CF8h/CFCh io slave port. It probes bus 0, devices DEV_FIRST..DEV_LAST (function 0) and sizes each present device's BAR0. It then assigns BAR0 an aligned base from a memory window and enables memory decode in the device's command register. It sits between the SoC reset/control logic and the bridge's io port, and owns that port exclusively while busy.

---
 rtl/pci_cfg_enumerator.sv | 238 +++++++++++++++++++++++
 tb/tb_pci_cfg_enumerator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_cfg_enumerator.sv
// Boot-time PCI config sequencer: probes bus 0 devices through the CF8h/CFCh io port,
// sizes BAR0, allocates an aligned base from a memory window and enables memory decode.
`timescale 1ns/1ps
module pci_cfg_enumerator #(
  parameter int unsigned DEV_FIRST  = 1,
  parameter int unsigned DEV_LAST   = 1,
  parameter logic [31:0] MEM_BASE   = 32'hE000_0000,
  parameter logic [31:0] MEM_LIMIT  = 32'hF000_0000,
  parameter int unsigned RD_TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic [31:0] present_mask,
  output logic [31:0] alloc_ptr,
  output logic        io_address,
  output logic        io_read,
  output logic        io_write,
  output logic [31:0] io_writedata,
  input  logic [31:0] io_readdata,
  input  logic        io_waitrequest,
  input  logic        io_readdatavalid
);

  typedef enum logic [3:0] {
    StIdle, StProbeA, StProbeR, StOffA, StOffW, StSzA, StSzW1, StSzR,
    StBarW, StOnA, StOnW, StNext, StDoneA, StDone
  } state_e;

  typedef enum logic [1:0] {OpIdle, OpIssue, OpWaitRd, OpRet} op_e;

  localparam logic [15:0] TmoLast = 16'(RD_TIMEOUT - 1);

  state_e      st_q, st_d;
  op_e         op_q, op_d;
  logic [4:0]  dev_q, dev_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] bar_q, bar_d;
  logic        skip_q, skip_d;
  logic        err_q, err_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] ptr_q, ptr_d;
  logic        rd_q, rd_d;
  logic        adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        op_req, req_rd, req_adr, op_done;
  logic [31:0] req_data;
  logic [31:0] size;
  logic [32:0] base33, end33;
  logic        fits;

  // Config address for device d, dword index ri (register offset >> 2), function 0.
  function automatic logic [31:0] cfg(input logic [4:0] d, input logic [5:0] ri);
    return {1'b1, 7'b0, 8'h00, d, 3'b000, ri, 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      op_q    <= OpIdle;
      dev_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
      bar_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
      mask_q  <= '0;
      ptr_q   <= MEM_BASE;
      rd_q    <= 1'b0;
      adr_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      st_q    <= st_d;
      op_q    <= op_d;
      dev_q   <= dev_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      bar_q   <= bar_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
    end
  end

  // Bus op requested by the current sequencer state.
  always_comb begin
    op_req   = 1'b1;
    req_rd   = 1'b0;
    req_adr  = 1'b0;
    req_data = '0;
    unique case (st_q)
      StProbeA: req_data = cfg(dev_q, 6'h00);
      StProbeR: begin req_rd = 1'b1; req_adr = 1'b1; end
      StOffA:   req_data = cfg(dev_q, 6'h01);
      StOffW:   req_adr = 1'b1;
      StSzA:    req_data = cfg(dev_q, 6'h04);
      StSzW1:   begin req_adr = 1'b1; req_data = 32'hFFFF_FFFF; end
      StSzR:    begin req_rd = 1'b1; req_adr = 1'b1; end
      StBarW:   begin req_adr = 1'b1; req_data = bar_q; end
      StOnA:    req_data = cfg(dev_q, 6'h01);
      StOnW:    begin req_adr = 1'b1; req_data = 32'h0000_0002; end
      StDoneA:  req_data = '0;
      default:  op_req = 1'b0;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    unique case (op_q)
      OpIdle: begin
        if (op_req) begin
          op_d    = OpIssue;
          rd_d    = req_rd;
          adr_d   = req_adr;
          wdata_d = req_data;
        end
      end
      OpIssue: begin
        tmo_d = '0;
        if (!io_waitrequest) op_d = rd_q ? OpWaitRd : OpRet;
      end
      OpWaitRd: begin
        if (io_readdatavalid) begin
          rdata_d = io_readdata;
          op_d    = OpRet;
        end else if (tmo_q == TmoLast) begin
          rdata_d = 32'hFFFF_FFFF;
          op_d    = OpRet;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: op_d = OpIdle;
    endcase
  end

  assign op_done = (op_q == OpRet);

  // 33-bit so that rounding up near the top of the address space shows up as a carry.
  always_comb begin
    size   = ~{rdata_q[31:4], 4'b0} + 32'd1;
    base33 = ({1'b0, ptr_q} + {1'b0, size} - 33'd1) & ~{1'b0, size - 32'd1};
    end33  = base33 + {1'b0, size};
    fits   = !base33[32] && (end33 <= {1'b0, MEM_LIMIT});
  end

  always_comb begin
    st_d   = st_q;
    dev_d  = dev_q;
    bar_d  = bar_q;
    skip_d = skip_q;
    err_d  = err_q;
    mask_d = mask_q;
    ptr_d  = ptr_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d   = StProbeA;
          dev_d  = 5'(DEV_FIRST);
          err_d  = 1'b0;
          mask_d = '0;
          ptr_d  = MEM_BASE;
        end
      end
      StProbeA: if (op_done) st_d = StProbeR;
      StProbeR: begin
        if (op_done) begin
          if (rdata_q[15:0] == 16'hFFFF) begin
            st_d = StNext;
          end else begin
            mask_d[dev_q] = 1'b1;
            st_d          = StOffA;
          end
        end
      end
      StOffA:   if (op_done) st_d = StOffW;
      StOffW:   if (op_done) st_d = StSzA;
      StSzA:    if (op_done) st_d = StSzW1;
      StSzW1:   if (op_done) st_d = StSzR;
      StSzR: begin
        if (op_done) begin
          st_d   = StBarW;
          bar_d  = '0;
          skip_d = 1'b1;
          if (rdata_q[0] || (rdata_q[31:4] == 28'd0)) begin
            skip_d = 1'b1;
          end else if (!fits) begin
            err_d = 1'b1;
          end else begin
            bar_d  = base33[31:0];
            ptr_d  = end33[31:0];
            skip_d = 1'b0;
          end
        end
      end
      StBarW:   if (op_done) st_d = skip_q ? StNext : StOnA;
      StOnA:    if (op_done) st_d = StOnW;
      StOnW:    if (op_done) st_d = StNext;
      StNext: begin
        if (dev_q == 5'(DEV_LAST)) begin
          st_d = StDoneA;
        end else begin
          dev_d = dev_q + 5'd1;
          st_d  = StProbeA;
        end
      end
      StDoneA:  if (op_done) st_d = StDone;
      default:  st_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (st_q != StIdle);
    done         = (st_q == StDone);
    err_overflow = err_q;
    present_mask = mask_q;
    alloc_ptr    = ptr_q;
    io_read      = (op_q == OpIssue) && rd_q;
    io_write     = (op_q == OpIssue) && !rd_q;
    io_address   = adr_q;
    io_writedata = wdata_q;
  end

endmodule

// File: tb/tb_pci_cfg_enumerator.sv
// Directed bench for pci_cfg_enumerator with a behavioural CF8h/CFCh bridge and
// config-space model for devices 1 and 2.
`timescale 1ns/1ps
module tb_pci_cfg_enumerator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_overflow;
  logic [31:0] present_mask, alloc_ptr;
  logic        io_address, io_read, io_write;
  logic [31:0] io_writedata;
  logic [31:0] io_readdata = '0;
  logic        io_waitrequest = 1'b0;
  logic        io_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  pci_cfg_enumerator #(
    .DEV_FIRST (1),
    .DEV_LAST  (2),
    .MEM_BASE  (32'hE000_0000),
    .MEM_LIMIT (32'hF000_0000),
    .RD_TIMEOUT(127)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .err_overflow    (err_overflow),
    .present_mask    (present_mask),
    .alloc_ptr       (alloc_ptr),
    .io_address      (io_address),
    .io_read         (io_read),
    .io_write        (io_write),
    .io_writedata    (io_writedata),
    .io_readdata     (io_readdata),
    .io_waitrequest  (io_waitrequest),
    .io_readdatavalid(io_readdatavalid)
  );

  int total = 0;
  int bad = 0;

  // Bridge / config-space model state
  int          cyc = 0, done_cnt = 0, both_err = 0, stab_err = 0;
  int          n_cf8 = 0, n_cfc_wr = 0, n_rd = 0;
  int          last_gap = 0, rd_acc_cyc = 0, stall_left = 0;
  bit          tmo_pending = 0, req_active = 0, rd_pending = 0, stall_en = 0, sz_rd_seen = 0;
  logic        p_rd, p_wr, p_adr;
  logic [31:0] p_dat, rd_val, cf8_reg;
  logic [31:0] cf8_log [64];
  bit          b_present [32];
  bit          b_sizing [32];
  logic [31:0] b_mask [32];
  logic [31:0] b_bar [32];
  logic [31:0] b_cmd [32];
  int          b_bar_wr [32];
  int          b_cmd_on [32];
  logic [4:0]  bd;
  logic [5:0]  br;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (io_read && io_write) both_err++;
    io_readdatavalid = 1'b0;
    if (!rst_n) begin
      req_active = 0;
      rd_pending = 0;
      io_waitrequest = 1'b0;
    end else begin
      if (rd_pending) begin
        io_readdatavalid = 1'b1;
        io_readdata = rd_val;
        rd_pending = 0;
      end
      if (io_read || io_write) begin
        if (!req_active) begin
          req_active = 1;
          p_rd = io_read; p_wr = io_write; p_adr = io_address; p_dat = io_writedata;
          stall_left = (stall_en && io_write && io_address) ? 5 : 0;
          if (tmo_pending) begin
            last_gap = cyc - rd_acc_cyc;
            tmo_pending = 0;
          end
        end else if (io_read !== p_rd || io_write !== p_wr || io_address !== p_adr ||
                     io_writedata !== p_dat) begin
          stab_err++;
        end
        if (stall_left > 0) begin
          io_waitrequest = 1'b1;
          stall_left--;
        end else begin
          io_waitrequest = 1'b0;
          req_active = 0;
          bd = cf8_reg[15:11];
          br = cf8_reg[7:2];
          if (io_write && !io_address) begin
            cf8_reg = io_writedata;
            if (n_cf8 < 64) cf8_log[n_cf8] = io_writedata;
            n_cf8++;
          end else if (io_write) begin
            n_cfc_wr++;
            if (br == 6'h01) begin
              b_cmd[bd] = io_writedata;
              if (io_writedata == 32'h2) b_cmd_on[bd]++;
            end else if (br == 6'h04) begin
              if (io_writedata == 32'hFFFF_FFFF) b_sizing[bd] = 1;
              else begin
                b_bar[bd] = io_writedata;
                b_sizing[bd] = 0;
                b_bar_wr[bd]++;
              end
            end
          end else begin
            n_rd++;
            if (br == 6'h04) sz_rd_seen = 1;
            if (cf8_reg[31] && b_present[bd]) begin
              rd_pending = 1;
              if (br == 6'h00) rd_val = {16'h0001, 16'h121A};
              else if (br == 6'h04) rd_val = b_sizing[bd] ? b_mask[bd] : b_bar[bd];
              else if (br == 6'h01) rd_val = b_cmd[bd];
              else rd_val = '0;
            end else begin
              tmo_pending = 1;
              rd_acc_cyc = cyc;
            end
          end
        end
      end else begin
        io_waitrequest = 1'b0;
        req_active = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup(input bit p1, input logic [31:0] m1, input bit p2,
                       input logic [31:0] m2, input bit stall);
    for (int i = 0; i < 32; i++) begin
      b_present[i] = 0; b_sizing[i] = 0; b_mask[i] = '0;
      b_bar[i] = 32'hDEAD_BEEF; b_cmd[i] = 32'h0000_0007; b_bar_wr[i] = 0; b_cmd_on[i] = 0;
    end
    for (int i = 0; i < 64; i++) cf8_log[i] = 32'hXXXX_XXXX;
    b_present[1] = p1; b_mask[1] = m1;
    b_present[2] = p2; b_mask[2] = m2;
    stall_en = stall;
    n_cf8 = 0; n_cfc_wr = 0; n_rd = 0; last_gap = 0; tmo_pending = 0;
    stab_err = 0; sz_rd_seen = 0; cf8_reg = '0;
  endtask

  task automatic run_scan(input string tag, input bit extra_start);
    int base_done;
    bit finished;
    base_done = done_cnt;
    finished = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    for (int n = 0; n < 3000 && !finished; n++) begin
      @(negedge clk);
      start = (extra_start && n == 20) ? 1'b1 : 1'b0;
      if (done_cnt != base_done) finished = 1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - base_done), 1);
    chk({tag, "_busy_after_done"}, 32'(busy), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err_overflow), 0);
    chk({tag, "_mask"}, present_mask, 0);
    chk({tag, "_alloc"}, alloc_ptr, 32'hE000_0000);
    chk({tag, "_io_rd"}, 32'(io_read), 0);
    chk({tag, "_io_wr"}, 32'(io_write), 0);
    chk({tag, "_io_adr"}, 32'(io_address), 0);
    chk({tag, "_io_wdata"}, io_writedata, 0);
  endtask

  initial begin
    setup(0, '0, 0, '0, 0);
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One device, 16 MiB BAR
    setup(1, 32'hFF00_0000, 0, '0, 0);
    run_scan("t1", 0);
    chk("t1_cf8_0", cf8_log[0], 32'h8000_0800);
    chk("t1_cf8_1", cf8_log[1], 32'h8000_0804);
    chk("t1_cf8_2", cf8_log[2], 32'h8000_0810);
    chk("t1_cf8_3", cf8_log[3], 32'h8000_0804);
    chk("t1_cf8_4", cf8_log[4], 32'h8000_1000);
    chk("t1_cf8_5", cf8_log[5], 32'h0000_0000);
    chk("t1_n_cf8", 32'(n_cf8), 6);
    chk("t1_n_cfc_wr", 32'(n_cfc_wr), 4);
    chk("t1_bar1", b_bar[1], 32'hE000_0000);
    chk("t1_cmd1", b_cmd[1], 32'h0000_0002);
    chk("t1_mask", present_mask, 32'h0000_0002);
    chk("t1_alloc", alloc_ptr, 32'hE100_0000);
    chk("t1_err", 32'(err_overflow), 0);
    chk("t1_tmo_gap", 32'(last_gap), 131);

    // No devices: every probe read times out
    setup(0, '0, 0, '0, 0);
    run_scan("t2", 0);
    chk("t2_n_cf8", 32'(n_cf8), 3);
    chk("t2_cf8_0", cf8_log[0], 32'h8000_0800);
    chk("t2_cf8_1", cf8_log[1], 32'h8000_1000);
    chk("t2_cf8_2", cf8_log[2], 32'h0000_0000);
    chk("t2_n_cfc_wr", 32'(n_cfc_wr), 0);
    chk("t2_mask", present_mask, 0);
    chk("t2_alloc", alloc_ptr, 32'hE000_0000);
    chk("t2_tmo_gap", 32'(last_gap), 131);

    // Two devices, second base aligned up
    setup(1, 32'hFFF0_0000, 1, 32'hFF00_0000, 0);
    run_scan("t3", 0);
    chk("t3_bar1", b_bar[1], 32'hE000_0000);
    chk("t3_bar2", b_bar[2], 32'hE100_0000);
    chk("t3_cmd1", b_cmd[1], 32'h2);
    chk("t3_cmd2", b_cmd[2], 32'h2);
    chk("t3_alloc", alloc_ptr, 32'hE200_0000);
    chk("t3_mask", present_mask, 32'h0000_0006);
    chk("t3_err", 32'(err_overflow), 0);

    // First BAR fills the window exactly, second overflows
    setup(1, 32'hF000_0000, 1, 32'hFF00_0000, 0);
    run_scan("t4", 0);
    chk("t4_bar1", b_bar[1], 32'hE000_0000);
    chk("t4_cmd_on1", 32'(b_cmd_on[1]), 1);
    chk("t4_err", 32'(err_overflow), 1);
    chk("t4_bar2", b_bar[2], 32'h0);
    chk("t4_bar2_wr", 32'(b_bar_wr[2]), 1);
    chk("t4_cmd_on2", 32'(b_cmd_on[2]), 0);
    chk("t4_cmd2", b_cmd[2], 32'h0);
    chk("t4_alloc", alloc_ptr, 32'hF000_0000);

    // IO BAR skipped; sticky error cleared by new start
    setup(1, 32'hFFFF_FF01, 1, 32'hFFFF_0000, 0);
    run_scan("t5", 0);
    chk("t5_bar1", b_bar[1], 32'h0);
    chk("t5_bar1_wr", 32'(b_bar_wr[1]), 1);
    chk("t5_cmd_on1", 32'(b_cmd_on[1]), 0);
    chk("t5_bar2", b_bar[2], 32'hE000_0000);
    chk("t5_alloc", alloc_ptr, 32'hE001_0000);
    chk("t5_err", 32'(err_overflow), 0);
    chk("t5_mask", present_mask, 32'h0000_0006);

    // Stalled CFCh writes plus an ignored start while busy
    setup(1, 32'hFFF0_0000, 1, 32'hFF00_0000, 1);
    run_scan("t6", 1);
    chk("t6_stable", 32'(stab_err), 0);
    chk("t6_n_cf8", 32'(n_cf8), 9);
    chk("t6_n_cfc_wr", 32'(n_cfc_wr), 8);
    chk("t6_n_rd", 32'(n_rd), 4);
    chk("t6_bar2", b_bar[2], 32'hE100_0000);
    chk("t6_alloc", alloc_ptr, 32'hE200_0000);
    chk("t6_mask", present_mask, 32'h0000_0006);

    // Asynchronous reset while waiting on the sizing read
    setup(1, 32'hFF00_0000, 0, '0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2000 && !sz_rd_seen; i++) @(negedge clk);
    chk("t7_sz_read_reached", 32'(sz_rd_seen), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t7_rst");
    repeat (3) @(negedge clk);
    chk("t7_no_req", 32'(io_read | io_write), 0);
    rst_n = 1'b1;
    setup(1, 32'hFF00_0000, 0, '0, 0);
    run_scan("t7", 0);
    chk("t7_cf8_0", cf8_log[0], 32'h8000_0800);
    chk("t7_bar1", b_bar[1], 32'hE000_0000);
    chk("t7_alloc", alloc_ptr, 32'hE100_0000);
    chk("t7_mask", present_mask, 32'h0000_0002);

    chk("rd_wr_both", 32'(both_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
